// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants, state encoding and control-word type for the
// multicycle MIPS-subset sequencer. Optional jump support: MC_JUMP_EN.
package mc_ctrl_pkg;

  localparam int OP_W  = 6;
  localparam int AOP_W = 3;

  // Opcodes as they appear in instruction bits [31:26]
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // ALU-op codes, same encoding the datapath ALU control expects
  localparam logic [AOP_W-1:0] AOP_ADD   = 3'b000;
  localparam logic [AOP_W-1:0] AOP_SUB   = 3'b001;
  localparam logic [AOP_W-1:0] AOP_RFUNC = 3'b010;
  localparam logic [AOP_W-1:0] AOP_ADDI  = 3'b011;
  localparam logic [AOP_W-1:0] AOP_SLTI  = 3'b100;
  localparam logic [AOP_W-1:0] AOP_ANDI  = 3'b101;
  localparam logic [AOP_W-1:0] AOP_ORI   = 3'b110;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select; the jump-target code exists only when jumps are built in
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MC_JUMP_EN
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [AOP_W-1:0] aop;
    logic [1:0]       pc_src;
    logic             instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_write:      1'b0,
    pc_write_cond: 1'b0,
    iord:          1'b0,
    mem_read:      1'b0,
    mem_write:     1'b0,
    ir_write:      1'b0,
    reg_dst:       1'b0,
    mem_to_reg:    1'b0,
    reg_write:     1'b0,
    alu_src_a:     1'b0,
    alu_src_b:     2'b00,
    aop:           3'b000,
    pc_src:        2'b00,
    instr_done:    1'b0
  };

  // True for every opcode the sequencer knows how to execute
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: ok = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:    ok = 1'b1;
`else
      OP_J:    ok = 1'b0;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for the immediate-arithmetic group
  function automatic logic [AOP_W-1:0] itype_aop(input logic [OP_W-1:0] op);
    logic [AOP_W-1:0] a;
    case (op)
      OP_ADDI: a = AOP_ADDI;
      OP_ANDI: a = AOP_ANDI;
      OP_SLTI: a = AOP_SLTI;
      OP_ORI:  a = AOP_ORI;
      default: a = AOP_ADD;
    endcase
    return a;
  endfunction

  // Drop every strobe but keep the selects, so a stalled cycle does nothing
  function automatic ctrl_t strip_strobes(input ctrl_t c);
    ctrl_t r;
    r               = c;
    r.pc_write      = 1'b0;
    r.pc_write_cond = 1'b0;
    r.mem_read      = 1'b0;
    r.mem_write     = 1'b0;
    r.ir_write      = 1'b0;
    r.reg_write     = 1'b0;
    r.instr_done    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state/opcode -> datapath control word.
// Optional jump state decoding: MC_JUMP_EN.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_e         state_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           mem_rdy_i,
  output ctrl_t          ctrl_o
);

  // Moore control word per state; only the memory-completing strobes look at mem_rdy
  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.aop       = AOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_rdy_i;
        ctrl_o.pc_write  = mem_rdy_i;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is examined
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.aop       = AOP_ADD;
        if (op_legal(opcode_i)) begin
          ctrl_o.instr_done = 1'b0;
        end else begin
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.aop       = AOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_rdy_i;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.aop       = AOP_RFUNC;
      end
      S_RWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.aop       = itype_aop(opcode_i);
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // The datapath gates this PC load with the ALU zero flag
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.aop           = AOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: begin
        ctrl_o = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle Moore sequencer for the MIPS-subset datapath.
// Holds the state register, next-state logic and the sticky illegal flag;
// control outputs come from mc_ctrl_outdec. Optional J support: MC_JUMP_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int AOPW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  UIn,
  input  logic            zero,
  input  logic            mem_rdy,
  input  logic            hold,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MRead,
  output logic            MWrite,
  output logic            IRWrite,
  output logic            RegDs,
  output logic            MtoR,
  output logic            Urw,
  output logic            ALUsrcA,
  output logic [1:0]      ALUsrcB,
  output logic [AOPW-1:0] AOp,
  output logic [1:0]      PCSrc,
  output logic            instr_done,
  output logic            illegal,
  output logic [3:0]      state_o
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  dec_s;
  ctrl_t  ctrl_s;

  // Branch resolution happens in the datapath (PCWriteCond & zero); the
  // sequencer itself never needs the flag.
  logic unused_zero_s;
  assign unused_zero_s = zero;

  mc_ctrl_outdec #(
    .OPW(OPW)
  ) u_outdec (
    .state_i   (state_q),
    .opcode_i  (UIn),
    .mem_rdy_i (mem_rdy),
    .ctrl_o    (dec_s)
  );

  // Next state and illegal flag; hold freezes everything, including a mem_rdy arriving now
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (UIn)
            OP_LW, OP_SW:                      state_d = S_MEMADR;
            OP_RTYPE:                          state_d = S_EXEC_R;
            OP_BEQ:                            state_d = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI: state_d = S_EXEC_I;
`ifdef MC_JUMP_EN
            OP_J:                              state_d = S_JUMP;
`endif
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: state_d = (UIn == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_d = S_FETCH;
        S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
        S_EXEC_R: state_d = S_RWB;
        S_RWB:    state_d = S_FETCH;
        S_EXEC_I: state_d = S_IWB;
        S_IWB:    state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
        S_JUMP:   state_d = S_FETCH;
`endif
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // State register and sticky illegal flag; reset returns to FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Output qualification: reset silences strobes and selects, hold silences only strobes
  always_comb begin
    ctrl_s = dec_s;
    if (!rst_n) begin
      ctrl_s = CTRL_IDLE;
    end else if (hold) begin
      ctrl_s = strip_strobes(dec_s);
    end else begin
      ctrl_s = dec_s;
    end
  end

  assign PCWrite     = ctrl_s.pc_write;
  assign PCWriteCond = ctrl_s.pc_write_cond;
  assign IorD        = ctrl_s.iord;
  assign MRead       = ctrl_s.mem_read;
  assign MWrite      = ctrl_s.mem_write;
  assign IRWrite     = ctrl_s.ir_write;
  assign RegDs       = ctrl_s.reg_dst;
  assign MtoR        = ctrl_s.mem_to_reg;
  assign Urw         = ctrl_s.reg_write;
  assign ALUsrcA     = ctrl_s.alu_src_a;
  assign ALUsrcB     = ctrl_s.alu_src_b;
  assign AOp         = ctrl_s.aop;
  assign PCSrc       = ctrl_s.pc_src;
  assign instr_done  = ctrl_s.instr_done;
  assign illegal     = illegal_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
// Honours MC_JUMP_EN for the J-opcode step.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] UIn;
  logic       zero;
  logic       mem_rdy;
  logic       hold;
  logic       PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite;
  logic       RegDs, MtoR, Urw, ALUsrcA, instr_done, illegal;
  logic [1:0] ALUsrcB, PCSrc;
  logic [2:0] AOp;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  // Strobe vector {PCWrite,PCWriteCond,MRead,MWrite,IRWrite,Urw,instr_done}
  localparam logic [6:0] B_PCW  = 7'b1000000;
  localparam logic [6:0] B_PCWC = 7'b0100000;
  localparam logic [6:0] B_MR   = 7'b0010000;
  localparam logic [6:0] B_MW   = 7'b0001000;
  localparam logic [6:0] B_IRW  = 7'b0000100;
  localparam logic [6:0] B_URW  = 7'b0000010;
  localparam logic [6:0] B_DONE = 7'b0000001;
  localparam logic [6:0] B_NONE = 7'b0000000;

  logic [6:0] stb;
  assign stb = {PCWrite, PCWriteCond, MRead, MWrite, IRWrite, Urw, instr_done};

  mc_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .UIn         (UIn),
    .zero        (zero),
    .mem_rdy     (mem_rdy),
    .hold        (hold),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MRead       (MRead),
    .MWrite      (MWrite),
    .IRWrite     (IRWrite),
    .RegDs       (RegDs),
    .MtoR        (MtoR),
    .Urw         (Urw),
    .ALUsrcA     (ALUsrcA),
    .ALUsrcB     (ALUsrcB),
    .AOp         (AOp),
    .PCSrc       (PCSrc),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; UIn = 6'b000000; zero = 1'b0; mem_rdy = 1'b0; hold = 1'b0;
    #3;
    chk("rst_state",   8'(state_o), 8'(S_FETCH));
    chk("rst_stb",     {1'b0, stb}, {1'b0, B_NONE});
    chk("rst_srcb",    8'(ALUsrcB), 8'd0);
    chk("rst_illegal", 8'(illegal), 8'd0);

    // Release reset with hold asserted: hold beats mem_rdy
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b1; mem_rdy = 1'b1; UIn = 6'b000000;
    #1;
    chk("hold_fetch_stb", {1'b0, stb}, {1'b0, B_NONE});
    step();
    chk("hold_fetch_state", 8'(state_o), 8'(S_FETCH));
    hold = 1'b0;
    #1;
    chk("fetch_stb",  {1'b0, stb}, {1'b0, B_PCW | B_MR | B_IRW});
    chk("fetch_srcb", 8'(ALUsrcB), 8'd1);

    // R-type: FETCH, DECODE, EXEC_R, RWB
    step();
    chk("r_dec_state", 8'(state_o), 8'(S_DECODE));
    chk("r_dec_srcb",  8'(ALUsrcB), 8'd3);
    chk("r_dec_stb",   {1'b0, stb}, {1'b0, B_NONE});
    step();
    chk("r_ex_state", 8'(state_o), 8'(S_EXEC_R));
    chk("r_ex_aop",   8'(AOp), 8'd2);
    chk("r_ex_srca",  8'(ALUsrcA), 8'd1);
    chk("r_ex_srcb",  8'(ALUsrcB), 8'd0);
    step();
    chk("r_wb_state", 8'(state_o), 8'(S_RWB));
    chk("r_wb_stb",   {1'b0, stb}, {1'b0, B_URW | B_DONE});
    chk("r_wb_regds", 8'(RegDs), 8'd1);
    chk("r_wb_mtor",  8'(MtoR), 8'd0);
    step();
    chk("r_end_state", 8'(state_o), 8'(S_FETCH));

    // LW with two mem_rdy-low cycles in MEMRD: 7 cycles total
    UIn = 6'b100011;
    step();
    chk("lw_dec_state", 8'(state_o), 8'(S_DECODE));
    step();
    chk("lw_adr_state", 8'(state_o), 8'(S_MEMADR));
    chk("lw_adr_srcb",  8'(ALUsrcB), 8'd2);
    chk("lw_adr_srca",  8'(ALUsrcA), 8'd1);
    mem_rdy = 1'b0;
    step();
    chk("lw_rd1_state", 8'(state_o), 8'(S_MEMRD));
    chk("lw_rd1_stb",   {1'b0, stb}, {1'b0, B_MR});
    chk("lw_rd1_iord",  8'(IorD), 8'd1);
    step();
    chk("lw_rd2_state", 8'(state_o), 8'(S_MEMRD));
    chk("lw_rd2_stb",   {1'b0, stb}, {1'b0, B_MR});
    chk("lw_rd2_iord",  8'(IorD), 8'd1);
    step();
    mem_rdy = 1'b1;
    #1;
    chk("lw_rd3_state", 8'(state_o), 8'(S_MEMRD));
    chk("lw_rd3_stb",   {1'b0, stb}, {1'b0, B_MR});
    chk("lw_rd3_iord",  8'(IorD), 8'd1);
    step();
    chk("lw_wb_state", 8'(state_o), 8'(S_MEMWB));
    chk("lw_wb_stb",   {1'b0, stb}, {1'b0, B_URW | B_DONE});
    chk("lw_wb_mtor",  8'(MtoR), 8'd1);
    chk("lw_wb_regds", 8'(RegDs), 8'd0);
    step();
    chk("lw_end_state", 8'(state_o), 8'(S_FETCH));

    // BEQ, preceded by a FETCH stall on mem_rdy low
    mem_rdy = 1'b0;
    #1;
    chk("fstall_stb", {1'b0, stb}, {1'b0, B_MR});
    step();
    chk("fstall_state", 8'(state_o), 8'(S_FETCH));
    mem_rdy = 1'b1; UIn = 6'b000100; zero = 1'b1;
    #1;
    chk("beq_fetch_stb", {1'b0, stb}, {1'b0, B_PCW | B_MR | B_IRW});
    step();
    step();
    chk("beq_br_state", 8'(state_o), 8'(S_BRANCH));
    chk("beq_br_stb",   {1'b0, stb}, {1'b0, B_PCWC | B_DONE});
    chk("beq_br_pcsrc", 8'(PCSrc), 8'd1);
    chk("beq_br_aop",   8'(AOp), 8'd1);
    step();
    chk("beq_end_state", 8'(state_o), 8'(S_FETCH));

    // ORI
    UIn = 6'b001101; zero = 1'b0;
    step();
    step();
    chk("ori_ex_state", 8'(state_o), 8'(S_EXEC_I));
    chk("ori_ex_aop",   8'(AOp), 8'd6);
    chk("ori_ex_srcb",  8'(ALUsrcB), 8'd2);
    step();
    chk("ori_wb_state", 8'(state_o), 8'(S_IWB));
    chk("ori_wb_stb",   {1'b0, stb}, {1'b0, B_URW | B_DONE});
    chk("ori_wb_regds", 8'(RegDs), 8'd0);
    step();
    chk("ori_end_state", 8'(state_o), 8'(S_FETCH));

    // J opcode: a 3-cycle jump when enabled, otherwise illegal
    UIn = 6'b000010;
    step();
`ifdef MC_JUMP_EN
    chk("j_dec_stb", {1'b0, stb}, {1'b0, B_NONE});
    step();
    chk("j_state", 8'(state_o), 8'(S_JUMP));
    chk("j_stb",   {1'b0, stb}, {1'b0, B_PCW | B_DONE});
    chk("j_pcsrc", 8'(PCSrc), 8'd2);
    step();
    chk("j_end_state",   8'(state_o), 8'(S_FETCH));
    chk("j_end_illegal", 8'(illegal), 8'd0);
`else
    chk("j_dec_stb",   {1'b0, stb}, {1'b0, B_DONE});
    chk("j_dec_pcsrc", 8'(PCSrc), 8'd0);
    step();
    chk("j_end_state",   8'(state_o), 8'(S_FETCH));
    chk("j_end_illegal", 8'(illegal), 8'd1);
`endif

    // Unsupported opcode 111111
    UIn = 6'b111111;
    step();
    chk("ill_dec_state", 8'(state_o), 8'(S_DECODE));
    chk("ill_dec_stb",   {1'b0, stb}, {1'b0, B_DONE});
    step();
    chk("ill_end_state",   8'(state_o), 8'(S_FETCH));
    chk("ill_end_illegal", 8'(illegal), 8'd1);

    // SW with hold during MEMWR while mem_rdy is high
    UIn = 6'b101011;
    step();
    step();
    step();
    hold = 1'b1;
    #1;
    chk("sw_hold_state", 8'(state_o), 8'(S_MEMWR));
    chk("sw_hold_stb",   {1'b0, stb}, {1'b0, B_NONE});
    chk("sw_hold_iord",  8'(IorD), 8'd1);
    step();
    chk("sw_frozen_state", 8'(state_o), 8'(S_MEMWR));
    hold = 1'b0;
    #1;
    chk("sw_wr_stb", {1'b0, stb}, {1'b0, B_MW | B_DONE});
    step();
    chk("sw_end_state",   8'(state_o), 8'(S_FETCH));
    chk("sticky_illegal", 8'(illegal), 8'd1);

    // LW interrupted by reset in MEMWB
    UIn = 6'b100011;
    step();
    step();
    step();
    step();
    chk("rwb_state", 8'(state_o), 8'(S_MEMWB));
    chk("rwb_stb",   {1'b0, stb}, {1'b0, B_URW | B_DONE});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stb",     {1'b0, stb}, {1'b0, B_NONE});
    chk("mid_rst_state",   8'(state_o), 8'(S_FETCH));
    chk("mid_rst_srcb",    8'(ALUsrcB), 8'd0);
    chk("mid_rst_mtor",    8'(MtoR), 8'd0);
    chk("mid_rst_illegal", 8'(illegal), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stb", {1'b0, stb}, {1'b0, B_PCW | B_MR | B_IRW});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle sequencer for the team's MIPS-subset datapath.
- Replaces the single-cycle opcode decode with a Moore FSM that issues per-cycle datapath controls.
- Covers FETCH, DECODE, EXECUTE, MEM and WRITEBACK steps for R-type, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI.
- Sits between the instruction register opcode field and the shared datapath: one memory port, ALU, register file, PC.

Parameters:
- OPW, 6, opcode width.
- AOPW, 3, ALU-op code width (same AOp encoding as the datapath ALU control).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- UIn  in  OPW  opcode from instruction register bits [31:26].
- zero  in  1  ALU zero flag (BEQ resolution).
- mem_rdy  in  1  memory completes access this cycle.
- hold  in  1  external stall request.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero=1.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MRead  out  1  memory read strobe.
- MWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDs  out  1  write-register select: 1 = rd, 0 = rt.
- MtoR  out  1  write-data select: 1 = memory data, 0 = ALUOut.
- Urw  out  1  register-file write enable.
- ALUsrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUsrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- AOp  out  AOPW  ALU op: 000 add, 001 sub/beq, 010 R-func, 011 addi, 100 slti, 101 andi, 110 ori.
- PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- illegal  out  1  sticky: unsupported opcode decoded.
- state_o  out  4  current state, for debug.

Behaviour:
- Clock and reset:
  - Single clock; rst_n asynchronous active-low.
  - Reset forces state = FETCH and illegal = 0.
  - While rst_n = 0, all strobes are 0: PCWrite, PCWriteCond, MRead, MWrite, IRWrite, Urw, instr_done.
  - Select outputs reset to 0.
- Outputs are Moore, decoded from the state register. Exception: memory-completing strobes are qualified with mem_rdy as noted below.
- FETCH:
  - Drives MRead = 1, IorD = 0, ALUsrcA = 0, ALUsrcB = 01, AOp = 000, PCSrc = 00.
  - IRWrite = PCWrite = mem_rdy.
  - Stays in FETCH until mem_rdy = 1, then goes to DECODE.
- DECODE:
  - Drives ALUsrcA = 0, ALUsrcB = 11, AOp = 000 (branch target into ALUOut).
  - 100011 or 101011 → MEMADR.
  - 000000 → EXEC_R.
  - 000100 → BRANCH.
  - 001000, 001100, 001010, 001101 → EXEC_I.
  - Any other opcode: set illegal, pulse instr_done, → FETCH.
- MEMADR: ALUsrcA = 1, ALUsrcB = 10, AOp = 000. Goes to MEMRD if UIn = 100011, else MEMWR.
- MEMRD: MRead = 1, IorD = 1. Waits for mem_rdy, then → MEMWB.
- MEMWB: Urw = 1, RegDs = 0, MtoR = 1, instr_done = 1, → FETCH.
- MEMWR: MWrite = 1, IorD = 1. Waits for mem_rdy; instr_done = mem_rdy; then → FETCH.
- EXEC_R: ALUsrcA = 1, ALUsrcB = 00, AOp = 010, → RWB.
- RWB: Urw = 1, RegDs = 1, MtoR = 0, instr_done = 1, → FETCH.
- EXEC_I: ALUsrcA = 1, ALUsrcB = 10, AOp per opcode (addi 011, andi 101, slti 100, ori 110), → IWB.
- IWB: Urw = 1, RegDs = 0, MtoR = 0, instr_done = 1, → FETCH.
- BRANCH:
  - ALUsrcA = 1, ALUsrcB = 00, AOp = 001, PCWriteCond = 1, PCSrc = 01, instr_done = 1.
  - → FETCH.
- Latency with mem_rdy tied high: LW 5, SW 4, R 4, I-type 4, BEQ 3 cycles. Each cycle mem_rdy is low adds one cycle in FETCH, MEMRD or MEMWR.
- hold = 1:
  - State frozen.
  - All strobes forced 0, including MRead/MWrite, so the memory transaction is re-issued when hold drops.
  - hold takes priority over mem_rdy arriving in the same cycle.
- illegal clears only on reset.
- Reset mid-instruction: immediate return to FETCH, no partial write issued.
- Undefined state codes → FETCH.

Optional Feature:
- Macro MC_JUMP_EN.
- When defined:
  - Opcode 000010 decodes in DECODE to state JUMP.
  - JUMP: PCWrite = 1, PCSrc = 10, instr_done = 1, → FETCH. J takes 3 cycles.
- When not defined: 000010 is illegal, and PCSrc never takes value 10.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - AOp constants;
  - ALUsrcB/PCSrc constants;
  - the state enum typedef, 4 bits.
- One sub-module, mc_ctrl_outdec: purely combinational state/opcode → control-word decoder. The FSM top holds only the state register, next-state logic and the illegal flag.

Test Plan:
- Reset, then mem_rdy = 1, UIn = 000000 → states FETCH, DECODE, EXEC_R, RWB. RWB shows Urw = 1, RegDs = 1, AOp was 010 in EXEC_R, instr_done pulses in cycle 4.
- UIn = 100011, mem_rdy low for 2 cycles in MEMRD → LW takes 7 cycles. IorD = 1 and MRead = 1 are held throughout MEMRD; MEMWB shows Urw = 1, MtoR = 1.
- UIn = 000100, zero = 1 → PCWriteCond = 1 and PCSrc = 01 in cycle 3; next state FETCH.
- UIn = 001101 → AOp = 110 and ALUsrcB = 10 in EXEC_I; IWB shows Urw = 1, RegDs = 0.
- UIn = 111111 → illegal = 1 after DECODE, back to FETCH. With MC_JUMP_EN, UIn = 000010 → PCWrite = 1 and PCSrc = 10 in cycle 3, illegal stays 0.
- hold = 1 during MEMWR while mem_rdy = 1 → MWrite = 0 and state unchanged. rst_n pulsed low in MEMWB → Urw = 0 immediately, state = FETCH.
